// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped BTB with 2-bit saturating direction counters,
// combinational lookup and mispredict/redirect, saturating branch/mispredict stats.
// Ports: clk/rst (async active-high); if_pc -> pred_hit/pred_taken/pred_target;
//   res_* resolve inputs -> mispredict/redirect_pc; br_cnt/mp_cnt statistics.
// Optional macro BRANCH_PRED_GSHARE_EN: XOR a global history register into the counter index.
module branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 64,
  parameter int HIST_W  = 6,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              res_valid,
  input  logic [ADDR_W-1:0] res_pc,
  input  logic              res_taken,
  input  logic [ADDR_W-1:0] res_target,
  input  logic              res_pred_taken,
  input  logic [ADDR_W-1:0] res_pred_target,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  mp_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  // Table state
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [ADDR_W-1:0]  tgt_q [ENTRIES];
  logic [1:0]         cnt_q [ENTRIES];
  logic [CNT_W-1:0]   br_cnt_q, mp_cnt_q;

  // Address split for lookup and update
  logic [IDX_W-1:0] lk_bi, up_bi, lk_ci, up_ci;
  logic [TAG_W-1:0] lk_tag, up_tag;

  assign lk_bi  = if_pc[IDX_W+1:2];
  assign lk_tag = if_pc[ADDR_W-1:IDX_W+2];
  assign up_bi  = res_pc[IDX_W+1:2];
  assign up_tag = res_pc[ADDR_W-1:IDX_W+2];

`ifdef BRANCH_PRED_GSHARE_EN
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [HIST_W:0]   ghr_shift;

  // Shift through a wider vector so HIST_W=1 needs no special case.
  assign ghr_shift = {ghr_q, res_taken};
  assign ghr_d     = ghr_shift[HIST_W-1:0];
  assign lk_ci     = lk_bi ^ IDX_W'(ghr_q);
  assign up_ci     = up_bi ^ IDX_W'(ghr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q <= '0;
    end else if (res_valid) begin
      ghr_q <= ghr_d;
    end
  end
  localparam bit ALLOC_SETS_CNT = 1'b0;
`else
  assign lk_ci = lk_bi;
  assign up_ci = up_bi;
  localparam bit ALLOC_SETS_CNT = 1'b1;
`endif

  // Lookup: purely combinational, reads pre-update state (no bypass).
  logic lk_hit;
  assign lk_hit      = valid_q[lk_bi] && (tag_q[lk_bi] == lk_tag);
  assign pred_hit    = lk_hit;
  assign pred_taken  = lk_hit && cnt_q[lk_ci][1];
  assign pred_target = lk_hit ? tgt_q[lk_bi] : '0;

  // Mispredict and redirect, same cycle as the resolve.
  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = '0;
    if (res_valid) begin
      mispredict  = (res_taken != res_pred_taken) ||
                    (res_taken && (res_target != res_pred_target));
      redirect_pc = res_taken ? res_target : res_pc + ADDR_W'(4);
    end
  end

  // Update-side next-state
  logic       up_hit, alloc;
  logic [1:0] cnt_cur, cnt_d;

  assign up_hit  = valid_q[up_bi] && (tag_q[up_bi] == up_tag);
  assign alloc   = res_taken && !up_hit;
  assign cnt_cur = cnt_q[up_ci];

  always_comb begin
    cnt_d = cnt_cur;
    if (alloc && ALLOC_SETS_CNT) begin
      cnt_d = 2'b10;  // fresh allocation starts weakly taken
    end else if (res_taken) begin
      if (cnt_cur != 2'b11) cnt_d = cnt_cur + 2'd1;
    end else begin
      if (cnt_cur != 2'b00) cnt_d = cnt_cur - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= 2'b01;
      end
    end else if (res_valid) begin
      cnt_q[up_ci] <= cnt_d;
      // Not-taken resolves never touch the BTB.
      if (res_taken) begin
        valid_q[up_bi] <= 1'b1;
        tag_q[up_bi]   <= up_tag;
        tgt_q[up_bi]   <= res_target;
      end
    end
  end

  // Saturating statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      if (res_valid && !(&br_cnt_q)) br_cnt_q <= br_cnt_q + CNT_W'(1);
      if (mispredict && !(&mp_cnt_q)) mp_cnt_q <= mp_cnt_q + CNT_W'(1);
    end
  end

  assign br_cnt = br_cnt_q;
  assign mp_cnt = mp_cnt_q;

  // Word-offset PC bits carry no information for a word-aligned ISA.
  logic unused_ok;
  assign unused_ok = ^{if_pc[1:0], res_pc[1:0], (HIST_W > 0)};

endmodule
